// File: rtl/tx_con.sv
// Transmit controller: streams DEPTH bytes from the buffer RAM to the UART TX core,
// one byte per tx_dv/tx_done handshake, then lights the active-low completion LED.
module tx_con #(
    parameter int ADDR_W  = 15,
    parameter int DEPTH   = 32768,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_tx,
    output logic [ADDR_W-1:0] r_address,
    input  logic [7:0]        r_data,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_done,
    output logic              outledTX
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAT_LOAD  = 2'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        BUSY,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] lat_cnt;

    // tx_byte and tx_dv are registered on the WAIT->LOAD edge so both are valid
    // together for the whole LOAD cycle; the DONE check precedes the increment,
    // so the address never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r_address <= '0;
            tx_byte   <= 8'h00;
            tx_dv     <= 1'b0;
            outledTX  <= 1'b1;
            lat_cnt   <= 2'd0;
        end else begin
            tx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_tx) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        tx_byte <= r_data;
                        tx_dv   <= 1'b1;
                        state   <= LOAD;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                LOAD: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (tx_done) begin
                        if (r_address == LAST_ADDR) begin
                            outledTX <= 1'b0;
                            state    <= DONE;
                        end else begin
                            r_address <= r_address + 1'b1;
                            state     <= en_tx ? FETCH : IDLE;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_con.sv
// Scoreboard bench for tx_con: three instances (DEPTH=4/MEM_LAT=1, DEPTH=4/MEM_LAT=3,
// DEPTH=1) with RAM models, tx_done responders and per-instance monitors.
module tb_tx_con;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: DEPTH=4, MEM_LAT=1
    logic       en_a, dv_a, led_a, auto_a, auto_done_a, man_done_a;
    logic       done_a;
    logic [1:0] addr_a;
    logic [7:0] rdata_a, byte_a;
    logic [7:0] ram_a [4];
    assign done_a = auto_done_a | man_done_a;

    // Instance B: DEPTH=4, MEM_LAT=3
    logic       en_b, dv_b, led_b, auto_b, done_b;
    logic [3:0] addr_b;
    logic [7:0] rdata_b, byte_b, pipe_b1, pipe_b2;
    logic [7:0] ram_b [16];

    // Instance C: DEPTH=1, MEM_LAT=1
    logic       en_c, dv_c, led_c, auto_c, done_c;
    logic [2:0] addr_c;
    logic [7:0] rdata_c, byte_c;
    logic [7:0] ram_c [8];

    tx_con #(.ADDR_W(2), .DEPTH(4), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .en_tx(en_a), .r_address(addr_a), .r_data(rdata_a),
        .tx_dv(dv_a), .tx_byte(byte_a), .tx_done(done_a), .outledTX(led_a)
    );
    tx_con #(.ADDR_W(4), .DEPTH(4), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .en_tx(en_b), .r_address(addr_b), .r_data(rdata_b),
        .tx_dv(dv_b), .tx_byte(byte_b), .tx_done(done_b), .outledTX(led_b)
    );
    tx_con #(.ADDR_W(3), .DEPTH(1), .MEM_LAT(1)) dut_c (
        .clk(clk), .rst(rst), .en_tx(en_c), .r_address(addr_c), .r_data(rdata_c),
        .tx_dv(dv_c), .tx_byte(byte_c), .tx_done(done_c), .outledTX(led_c)
    );

    // RAM models with one- and three-cycle read latency
    always @(posedge clk) begin
        rdata_a <= ram_a[addr_a];
        rdata_c <= ram_c[addr_c];
        pipe_b1 <= ram_b[addr_b];
        pipe_b2 <= pipe_b1;
        rdata_b <= pipe_b2;
    end

    logic [7:0] exp_a[$], exp_b[$], exp_c[$];
    int dv_cnt_a = 0, dv_cnt_b = 0, dv_cnt_c = 0;
    int dv_cyc_a = 0;
    int done_cyc_a = 0, done_cyc_b = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Monitors: every tx_dv pops the next expected byte
    logic [7:0] pop_a, pop_b, pop_c;
    initial forever begin
        @(negedge clk);
        if (dv_a) begin
            dv_cnt_a++;
            dv_cyc_a = cyc;
            if (exp_a.size() == 0) begin
                tests++; failed++;
                $display("[TB] FAIL a_unexpected_dv: got byte 0x%0h, expected no strobe", byte_a);
            end else begin
                pop_a = exp_a.pop_front();
                checkOutput("a_tx_byte", byte_a, pop_a);
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (dv_b) begin
            if (dv_cnt_b > 0) checkOutput("b_done_to_dv_gap", cyc - done_cyc_b, 5);
            dv_cnt_b++;
            if (exp_b.size() == 0) begin
                tests++; failed++;
                $display("[TB] FAIL b_unexpected_dv: got byte 0x%0h, expected no strobe", byte_b);
            end else begin
                pop_b = exp_b.pop_front();
                checkOutput("b_tx_byte", byte_b, pop_b);
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (dv_c) begin
            dv_cnt_c++;
            if (exp_c.size() == 0) begin
                tests++; failed++;
                $display("[TB] FAIL c_unexpected_dv: got byte 0x%0h, expected no strobe", byte_c);
            end else begin
                pop_c = exp_c.pop_front();
                checkOutput("c_tx_byte", byte_c, pop_c);
            end
        end
    end

    // UART TX models: answer each strobe with a tx_done pulse ten cycles later
    initial forever begin
        @(negedge clk);
        if (dv_a && auto_a) begin
            repeat (10) @(posedge clk);
            #1;
            if (auto_a) begin
                auto_done_a = 1'b1;
                done_cyc_a = cyc;
                @(posedge clk);
                #1;
                auto_done_a = 1'b0;
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (dv_b && auto_b) begin
            repeat (10) @(posedge clk);
            #1;
            done_b = 1'b1;
            done_cyc_b = cyc;
            @(posedge clk);
            #1;
            done_b = 1'b0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (dv_c && auto_c) begin
            repeat (10) @(posedge clk);
            #1;
            done_c = 1'b1;
            @(posedge clk);
            #1;
            done_c = 1'b0;
        end
    end

    function automatic int dvCount(input int which);
        case (which)
            0:       return dv_cnt_a;
            1:       return dv_cnt_b;
            default: return dv_cnt_c;
        endcase
    endfunction

    function automatic logic ledOf(input int which);
        case (which)
            0:       return led_a;
            1:       return led_b;
            default: return led_c;
        endcase
    endfunction

    task automatic waitDv(input int which, input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (dvCount(which) >= target) break;
            tick(1);
        end
        checkOutput(name, dvCount(which), target);
    endtask

    task automatic waitLed(input int which, input int budget, input string name, output int at_cyc);
        for (int i = 0; i < budget; i++) begin
            if (ledOf(which) == 1'b0) break;
            tick(1);
        end
        at_cyc = cyc;
        checkOutput(name, ledOf(which), 0);
    endtask

    task automatic applyStimulus(input int which, input logic en);
        case (which)
            0:       en_a = en;
            1:       en_b = en;
            default: en_c = en;
        endcase
    endtask

    task automatic applyReset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    int base, start, led_cyc;

    initial begin
        rst = 1'b1;
        en_a = 0; en_b = 0; en_c = 0;
        auto_a = 0; auto_b = 0; auto_c = 0;
        auto_done_a = 0; man_done_a = 0; done_b = 0; done_c = 0;
        ram_a = '{8'h41, 8'h42, 8'h43, 8'h44};
        foreach (ram_b[i]) ram_b[i] = 8'h00;
        ram_b[0] = 8'hA5; ram_b[1] = 8'h5A; ram_b[2] = 8'hC3; ram_b[3] = 8'h3C;
        foreach (ram_c[i]) ram_c[i] = 8'h00;
        ram_c[0] = 8'h99;
        tick(3);
        checkOutput("reset_addr", addr_a, 0);
        checkOutput("reset_dv", dv_a, 0);
        checkOutput("reset_byte", byte_a, 0);
        checkOutput("reset_led", led_a, 1);
        rst = 1'b0;
        tick(2);

        // Full transfer of four bytes
        exp_a.push_back(8'h41); exp_a.push_back(8'h42);
        exp_a.push_back(8'h43); exp_a.push_back(8'h44);
        base = dv_cnt_a;
        auto_a = 1;
        start = cyc;
        applyStimulus(0, 1);
        waitDv(0, base + 1, 20, "a_first_dv");
        checkOutput("a_first_dv_latency", dv_cyc_a - start, 3);
        waitDv(0, base + 4, 100, "a_four_dv");
        waitLed(0, 40, "a_led_done", led_cyc);
        checkOutput("a_led_after_last_done", led_cyc - done_cyc_a, 1);
        checkOutput("a_last_addr", addr_a, 3);
        tick(10);
        checkOutput("a_no_dv_in_done", dv_cnt_a, base + 4);

        // Asynchronous reset asserted mid-cycle from DONE
        applyStimulus(0, 0);
        auto_a = 0;
        rst = 1'b1;
        #1;
        checkOutput("midcycle_rst_addr", addr_a, 0);
        checkOutput("midcycle_rst_dv", dv_a, 0);
        checkOutput("midcycle_rst_byte", byte_a, 0);
        checkOutput("midcycle_rst_led", led_a, 1);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Pause during the second byte, resume later
        exp_a.push_back(8'h41); exp_a.push_back(8'h42);
        exp_a.push_back(8'h43); exp_a.push_back(8'h44);
        base = dv_cnt_a;
        auto_a = 1;
        applyStimulus(0, 1);
        waitDv(0, base + 2, 40, "pause_second_dv");
        applyStimulus(0, 0);
        tick(20);
        checkOutput("pause_addr", addr_a, 2);
        checkOutput("pause_no_dv", dv_cnt_a, base + 2);
        checkOutput("pause_led", led_a, 1);
        applyStimulus(0, 1);
        waitDv(0, base + 4, 100, "resume_dv");
        waitLed(0, 40, "resume_led_done", led_cyc);
        checkOutput("resume_last_addr", addr_a, 3);
        applyStimulus(0, 0);
        auto_a = 0;
        applyReset();

        // Spurious handshakes
        base = dv_cnt_a;
        man_done_a = 1;
        tick(2);
        man_done_a = 0;
        tick(3);
        checkOutput("idle_done_addr", addr_a, 0);
        checkOutput("idle_done_no_dv", dv_cnt_a, base);
        exp_a.push_back(8'h41); exp_a.push_back(8'h42);
        applyStimulus(0, 1);
        waitDv(0, base + 1, 20, "spur_first_dv");
        man_done_a = 1;
        tick(1);
        man_done_a = 0;
        tick(5);
        checkOutput("load_done_ignored_addr", addr_a, 0);
        checkOutput("load_done_ignored_dv", dv_cnt_a, base + 1);
        man_done_a = 1;
        tick(3);
        man_done_a = 0;
        tick(5);
        checkOutput("held_done_one_advance", addr_a, 1);
        checkOutput("held_done_dv", dv_cnt_a, base + 2);
        applyStimulus(0, 0);
        man_done_a = 1;
        tick(1);
        man_done_a = 0;
        tick(3);
        checkOutput("spur_final_addr", addr_a, 2);
        applyReset();

        // Reset during BUSY, then restart from address 0
        exp_a.push_back(8'h41); exp_a.push_back(8'h42);
        base = dv_cnt_a;
        auto_a = 1;
        applyStimulus(0, 1);
        waitDv(0, base + 2, 40, "busy_rst_dv");
        tick(3);
        checkOutput("busy_addr", addr_a, 1);
        auto_a = 0;
        applyStimulus(0, 0);
        rst = 1'b1;
        #1;
        checkOutput("busy_rst_addr", addr_a, 0);
        checkOutput("busy_rst_led", led_a, 1);
        tick(1);
        rst = 1'b0;
        tick(15);
        exp_a.push_back(8'h41); exp_a.push_back(8'h42);
        exp_a.push_back(8'h43); exp_a.push_back(8'h44);
        base = dv_cnt_a;
        auto_a = 1;
        applyStimulus(0, 1);
        waitDv(0, base + 4, 120, "restart_dv");
        waitLed(0, 40, "restart_led_done", led_cyc);
        checkOutput("restart_last_addr", addr_a, 3);

        // Three-cycle RAM latency
        exp_b.push_back(8'hA5); exp_b.push_back(8'h5A);
        exp_b.push_back(8'hC3); exp_b.push_back(8'h3C);
        auto_b = 1;
        applyStimulus(1, 1);
        waitDv(1, 4, 150, "b_four_dv");
        waitLed(1, 40, "b_led_done", led_cyc);
        checkOutput("b_last_addr", addr_b, 3);

        // DEPTH=1, then en_tx toggling in DONE
        exp_c.push_back(8'h99);
        auto_c = 1;
        applyStimulus(2, 1);
        waitLed(2, 40, "c_led_done", led_cyc);
        checkOutput("c_addr", addr_c, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2, 0);
            tick(2);
            applyStimulus(2, 1);
            tick(2);
        end
        checkOutput("c_single_dv", dv_cnt_c, 1);
        checkOutput("c_led_held", led_c, 0);

        checkOutput("a_queue_drained", exp_a.size(), 0);
        checkOutput("b_queue_drained", exp_b.size(), 0);
        checkOutput("c_queue_drained", exp_c.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
